// File: rtl/rect_plotter.sv
// Rectangle fill/border engine for the 160x120 VGA framebuffer.
// Emits one raster-ordered pixel write per clock after a start strobe.
module rect_plotter #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                start,
    input  logic [X_W-1:0]      x0,
    input  logic [Y_W-1:0]      y0,
    input  logic [X_W-1:0]      width,
    input  logic [Y_W-1:0]      height,
    input  logic [COLOUR_W-1:0] fill_colour,
    input  logic [COLOUR_W-1:0] border_colour,
    input  logic                border_en,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                busy,
    output logic                done
);
    localparam logic [X_W:0] SCR_W = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0] SCR_H = (Y_W+1)'(SCREEN_H);

    typedef enum logic [1:0] {IDLE, DRAW, FINISH} state_t;

    typedef struct packed {
        logic [X_W-1:0]      x;
        logic [Y_W-1:0]      y;
        logic [COLOUR_W-1:0] colour;
        logic                plot;
    } pix_t;

    state_t              state;
    logic [X_W-1:0]      cx, sx0, sw;
    logic [Y_W-1:0]      cy, sy0, sh;
    logic [COLOUR_W-1:0] sfill, sbord;
    logic                sben;

    logic [X_W-1:0] nx;
    logic [Y_W-1:0] ny;
    logic           last, emit;
    pix_t           pix;

    // Sums are one bit wider so an off-screen rectangle never wraps onto the screen.
    function automatic pix_t pixel(
        input logic [X_W-1:0]      px0, pw, pcx,
        input logic [Y_W-1:0]      py0, ph, pcy,
        input logic [COLOUR_W-1:0] pfill, pbord,
        input logic                pben
    );
        logic [X_W:0] xs;
        logic [Y_W:0] ys;
        logic         on_edge;
        pix_t         p;
        xs = {1'b0, px0} + {1'b0, pcx};
        ys = {1'b0, py0} + {1'b0, pcy};
        on_edge = (pcx == '0) || (pcx == pw - X_W'(1)) ||
                  (pcy == '0) || (pcy == ph - Y_W'(1));
        p.x      = xs[X_W-1:0];
        p.y      = ys[Y_W-1:0];
        p.colour = (pben && on_edge) ? pbord : pfill;
        p.plot   = (xs < SCR_W) && (ys < SCR_H);
        return p;
    endfunction

    always_comb begin
        nx   = cx + X_W'(1);
        ny   = cy;
        if (cx == sw - X_W'(1)) begin
            nx = '0;
            ny = cy + Y_W'(1);
        end
        last = (cx == sw - X_W'(1)) && (cy == sh - Y_W'(1));
        emit = 1'b0;
        // The first pixel comes straight from the command inputs so it lands in cycle k+1.
        if (state == IDLE) begin
            pix  = pixel(x0, width, '0, y0, height, '0, fill_colour, border_colour, border_en);
            emit = start && (width != '0) && (height != '0);
        end else begin
            pix  = pixel(sx0, sw, nx, sy0, sh, ny, sfill, sbord, sben);
            emit = (state == DRAW) && !last;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            x      <= '0;
            y      <= '0;
            colour <= '0;
            plot   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            cx     <= '0;
            cy     <= '0;
            sx0    <= '0;
            sy0    <= '0;
            sw     <= '0;
            sh     <= '0;
            sfill  <= '0;
            sbord  <= '0;
            sben   <= 1'b0;
        end else begin
            done <= 1'b0;
            plot <= emit && pix.plot;
            if (emit && pix.plot) begin
                x      <= pix.x;
                y      <= pix.y;
                colour <= pix.colour;
            end
            case (state)
                IDLE: if (start) begin
                    sx0   <= x0;
                    sy0   <= y0;
                    sw    <= width;
                    sh    <= height;
                    sfill <= fill_colour;
                    sbord <= border_colour;
                    sben  <= border_en;
                    cx    <= '0;
                    cy    <= '0;
                    if (width == '0 || height == '0) begin
                        state <= FINISH;
                        done  <= 1'b1;
                    end else begin
                        state <= DRAW;
                        busy  <= 1'b1;
                    end
                end
                DRAW: if (last) begin
                    state <= FINISH;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else begin
                    cx <= nx;
                    cy <= ny;
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rect_plotter.sv
// Directed bench for rect_plotter: table of rectangle commands plus
// hand-written reset, ignored-start and back-to-back sequences.
module tb_rect_plotter;
    logic       clock = 1'b0, resetn = 1'b0, start = 1'b0;
    logic [7:0] x0 = '0, width = '0;
    logic [6:0] y0 = '0, height = '0;
    logic [2:0] fill_colour = '0, border_colour = '0;
    logic       border_en = 1'b0;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot, busy, done;

    int n_checks = 0, n_fail = 0;

    rect_plotter dut (
        .clock(clock), .resetn(resetn), .start(start),
        .x0(x0), .y0(y0), .width(width), .height(height),
        .fill_colour(fill_colour), .border_colour(border_colour), .border_en(border_en),
        .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    typedef struct {
        string name;
        int    x0, y0, w, h, fill, bord, ben;
        int    exp_plots, exp_done, exp_bcnt;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic issue(input int ix0, iy0, iw, ih, ifill, ibord, iben);
        x0 = 8'(ix0); y0 = 7'(iy0); width = 8'(iw); height = 7'(ih);
        fill_colour = 3'(ifill); border_colour = 3'(ibord); border_en = 1'(iben);
        start = 1'b1;
    endtask

    task automatic scramble();
        start = 1'b0;
        x0 = 8'd77; y0 = 7'd77; width = 8'd9; height = 7'd9;
        fill_colour = ~fill_colour; border_colour = ~border_colour; border_en = ~border_en;
    endtask

    // Returns at the negedge of the cycle where done is high.
    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 500) begin
            @(negedge clock);
            n++;
        end
        if (!done) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic run_cmd(input vec_t v);
        int n, plots, bcnt, busy_cnt, done_at, cx, cy, ex, ey, ecol, elx, ely, exp_plot;
        @(negedge clock);
        issue(v.x0, v.y0, v.w, v.h, v.fill, v.bord, v.ben);
        @(negedge clock);
        scramble();
        n = 1; done_at = 0; plots = 0; bcnt = 0; busy_cnt = 0; elx = -1; ely = -1;
        while (done_at == 0 && n < 2000) begin
            if (busy && done) chk({v.name, "_busy_done"}, 1, 0);
            if (busy) busy_cnt++;
            if (done) begin
                done_at = n;
                chk({v.name, "_done_plot"}, plot, 0);
            end else if (n <= v.w * v.h) begin
                cx = (n - 1) % v.w;
                cy = (n - 1) / v.w;
                ex = v.x0 + cx;
                ey = v.y0 + cy;
                exp_plot = (ex < 160 && ey < 120) ? 1 : 0;
                ecol = (v.ben != 0 && (cx == 0 || cx == v.w - 1 || cy == 0 || cy == v.h - 1))
                       ? v.bord : v.fill;
                chk({v.name, "_plot"}, plot, exp_plot);
                if (exp_plot != 0) begin
                    chk({v.name, "_x"}, x, ex);
                    chk({v.name, "_y"}, y, ey);
                    chk({v.name, "_colour"}, colour, ecol);
                    elx = ex; ely = ey;
                end
            end
            if (plot) begin
                plots++;
                if (colour == 3'(v.bord)) bcnt++;
            end
            n++;
            if (done_at == 0) @(negedge clock);
        end
        chk({v.name, "_done_cycle"}, done_at, v.exp_done);
        chk({v.name, "_plot_count"}, plots, v.exp_plots);
        chk({v.name, "_border_count"}, bcnt, v.exp_bcnt);
        chk({v.name, "_busy_cycles"}, busy_cnt, v.w * v.h);
        if (elx >= 0) begin
            chk({v.name, "_hold_x"}, x, elx);
            chk({v.name, "_hold_y"}, y, ely);
        end
    endtask

    initial begin
        int dones, plots, bad, busies;

        //           name       x0   y0   w   h  fill  bord ben plots done bcnt
        vecs[0] = '{"basic",     5,   3,  3,  2, 3'b100, 3'b010, 0,  6,  7,  0};
        vecs[1] = '{"border",    0,   0,  4,  3, 3'b001, 3'b111, 1, 12, 13, 10};
        vecs[2] = '{"clip",    158, 119,  4,  2, 3'b010, 3'b101, 0,  2,  9,  0};
        vecs[3] = '{"empty_w",  10,  10,  0,  5, 3'b111, 3'b000, 0,  0,  1,  0};
        vecs[4] = '{"empty_h",  10,  10,  7,  0, 3'b111, 3'b000, 0,  0,  1,  0};
        vecs[5] = '{"one_px",  159, 119,  1,  1, 3'b011, 3'b110, 1,  1,  2,  1};
        vecs[6] = '{"x_wrap",  250,  10, 10,  1, 3'b001, 3'b010, 0,  0, 11,  0};
        vecs[7] = '{"y_wrap",   40, 125,  2,  5, 3'b001, 3'b010, 0,  0, 11,  0};
        vecs[8] = '{"all_bord", 10,  20,  2,  2, 3'b001, 3'b100, 1,  4,  5,  4};

        #1;
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_colour", colour, 0);
        chk("rst_plot", plot, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;

        for (int i = 0; i < 9; i++) run_cmd(vecs[i]);

        // Start strobes during a draw must not disturb it or queue a second command.
        @(negedge clock);
        issue(5, 3, 3, 2, 3'b100, 3'b010, 0);
        @(negedge clock);
        scramble();
        dones = 0; plots = 0; bad = 0;
        for (int n = 1; n <= 20; n++) begin
            if (n == 2 || n == 3 || n == 7) issue(100, 50, 5, 5, 3'b011, 3'b011, 0);
            else start = 1'b0;
            if (done) dones++;
            if (plot) begin
                plots++;
                if (x < 8'd5 || x > 8'd7 || y < 7'd3 || y > 7'd4 || colour != 3'b100) bad++;
            end
            @(negedge clock);
        end
        start = 1'b0;
        chk("midstart_dones", dones, 1);
        chk("midstart_plots", plots, 6);
        chk("midstart_bad_pixels", bad, 0);

        // A start seen only in the FINISH cycle is dropped.
        repeat (3) @(negedge clock);
        issue(60, 60, 1, 1, 3'b010, 3'b010, 0);
        @(negedge clock);
        scramble();
        wait_done("fin_ign_a");
        issue(70, 70, 5, 5, 3'b001, 3'b001, 0);
        @(negedge clock);
        start = 1'b0;
        busies = 0; plots = 0;
        repeat (6) begin
            if (busy) busies++;
            if (plot) plots++;
            @(negedge clock);
        end
        chk("finish_start_busy", busies, 0);
        chk("finish_start_plots", plots, 0);

        // Back-to-back: start in the IDLE cycle right after done.
        issue(1, 1, 2, 1, 3'b101, 3'b101, 0);
        @(negedge clock);
        scramble();
        wait_done("b2b_a");
        @(negedge clock);
        chk("b2b_idle_busy", busy, 0);
        issue(30, 40, 2, 2, 3'b110, 3'b001, 1);
        @(negedge clock);
        scramble();
        chk("b2b_first_plot", plot, 1);
        chk("b2b_first_x", x, 30);
        chk("b2b_first_y", y, 40);
        chk("b2b_first_colour", colour, 3'b001);
        chk("b2b_busy", busy, 1);
        wait_done("b2b_b");

        // Reset in the middle of a 10x10 draw.
        @(negedge clock);
        issue(20, 20, 10, 10, 3'b101, 3'b010, 0);
        @(negedge clock);
        scramble();
        repeat (4) @(negedge clock);
        chk("pre_reset_busy", busy, 1);
        chk("pre_reset_plot", plot, 1);
        @(posedge clock);
        #2 resetn = 1'b0;
        #1;
        chk("async_rst_plot", plot, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_done", done, 0);
        @(negedge clock);
        resetn = 1'b1;
        dones = 0; busies = 0; plots = 0;
        repeat (120) begin
            @(negedge clock);
            if (done) dones++;
            if (busy) busies++;
            if (plot) plots++;
        end
        chk("post_rst_dones", dones, 0);
        chk("post_rst_busy", busies, 0);
        chk("post_rst_plots", plots, 0);

        run_cmd(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
